// File: rtl/fwrisc_uart_wrapper.sv
// UART program loader for the fwrisc FPGA top.
// Receives an 8N1 byte stream into a MEM_DEPTH x 8 program RAM, echoes each
// accepted byte on tx and flags per-byte progress, completion and overrun.
//
// RX FSM
//   state     | meaning
//   RX_IDLE   | line idle, waiting for a falling edge
//   RX_START  | confirming the start bit at its centre
//   RX_DATA   | sampling 8 data bits, LSB first
//   RX_STOP   | sampling the stop bit
//   RX_WAIT   | framing error seen, waiting for the line to return high
//
// TX FSM
//   state     | meaning
//   TX_IDLE   | tx high, waiting for a held byte and a tick
//   TX_START  | driving the start bit
//   TX_DATA   | driving 8 data bits, LSB first
//   TX_STOP   | driving the stop bit
module fwrisc_uart_wrapper #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int MEM_DEPTH = 4096
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         rx,
    output logic                         tx,
    output logic                         program_receiving,
    output logic                         program_done,
    output logic                         program_ov,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_raddr,
    output logic [7:0]                   mem_rdata
);

    localparam int AW    = $clog2(MEM_DEPTH);
    localparam int DIV   = CLK_FREQ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(DIV - 1);
    localparam logic [AW-1:0]    LAST_ADDR = AW'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic [DIV_W-1:0] div_cnt;
    logic             tick16;
    logic             rx_meta, rx_sync;

    rx_state_t        rx_state, rx_state_n;
    logic [3:0]       rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             rx_valid;

    logic             accept;
    logic             mem_we;
    logic [AW-1:0]    wptr;
    logic [7:0]       mem [MEM_DEPTH];

    logic             hold_full;
    logic [7:0]       hold_data;
    logic             tx_take;
    tx_state_t        tx_state, tx_state_n;
    logic [3:0]       tx_cnt, tx_cnt_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             tx_n;

    // Free-running down-counter; terminal count gives the 16x bit-rate tick.
    always_ff @(posedge clock) begin
        if (reset)
            div_cnt <= DIV_LOAD;
        else if (div_cnt == '0)
            div_cnt <= DIV_LOAD;
        else
            div_cnt <= div_cnt - DIV_W'(1);
    end

    assign tick16 = (div_cnt == '0);

    // Two-flop synchroniser for the asynchronous serial input; idles high.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // RX state and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // RX next-state: start bit checked after 8 ticks, then every 16 ticks.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_valid   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = 4'd7;
                end
            end
            RX_START: begin
                if (tick16) begin
                    if (rx_cnt == '0) begin
                        if (!rx_sync) begin
                            rx_state_n = RX_DATA;
                            rx_cnt_n   = 4'd15;
                            rx_bit_n   = '0;
                        end else begin
                            rx_state_n = RX_IDLE;
                        end
                    end else begin
                        rx_cnt_n = rx_cnt - 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick16) begin
                    if (rx_cnt == '0) begin
                        rx_shift_n = {rx_sync, rx_shift[7:1]};
                        rx_cnt_n   = 4'd15;
                        rx_bit_n   = rx_bit + 3'd1;
                        if (rx_bit == 3'd7)
                            rx_state_n = RX_STOP;
                    end else begin
                        rx_cnt_n = rx_cnt - 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick16) begin
                    if (rx_cnt == '0) begin
                        if (rx_sync) begin
                            rx_valid   = 1'b1;
                            rx_state_n = RX_IDLE;
                        end else begin
                            rx_state_n = RX_WAIT;
                        end
                    end else begin
                        rx_cnt_n = rx_cnt - 4'd1;
                    end
                end
            end
            RX_WAIT: begin
                if (rx_sync)
                    rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    assign accept = rx_valid && !program_done;
    assign mem_we = accept && !reset;

    // Loader: write pointer stops at the last address instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr              <= '0;
            program_receiving <= 1'b0;
            program_done      <= 1'b0;
            program_ov        <= 1'b0;
        end else begin
            program_receiving <= accept;
            if (accept) begin
                if (wptr == LAST_ADDR)
                    program_done <= 1'b1;
                else
                    wptr <= wptr + AW'(1);
            end
            if (rx_valid && program_done)
                program_ov <= 1'b1;
        end
    end

    // Program RAM: contents survive reset; read returns old data on a collision.
    always_ff @(posedge clock) begin
        if (mem_we)
            mem[wptr] <= rx_shift;
        mem_rdata <= mem[mem_raddr];
    end

    // Echo holding register; a new byte overwrites one not yet sent.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= rx_shift;
        end else if (tx_take) begin
            hold_full <= 1'b0;
        end
    end

    // TX state, datapath and registered line output.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx       <= tx_n;
        end
    end

    // TX next-state: each bit held for 16 ticks; line level follows next state.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_take    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (hold_full && tick16) begin
                    tx_take    = 1'b1;
                    tx_state_n = TX_START;
                    tx_cnt_n   = 4'd15;
                    tx_shift_n = hold_data;
                end
            end
            TX_START: begin
                if (tick16) begin
                    if (tx_cnt == '0) begin
                        tx_state_n = TX_DATA;
                        tx_cnt_n   = 4'd15;
                        tx_bit_n   = '0;
                    end else begin
                        tx_cnt_n = tx_cnt - 4'd1;
                    end
                end
            end
            TX_DATA: begin
                if (tick16) begin
                    if (tx_cnt == '0) begin
                        tx_cnt_n = 4'd15;
                        if (tx_bit == 3'd7) begin
                            tx_state_n = TX_STOP;
                        end else begin
                            tx_bit_n   = tx_bit + 3'd1;
                            tx_shift_n = {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt_n = tx_cnt - 4'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tick16) begin
                    if (tx_cnt == '0)
                        tx_state_n = TX_IDLE;
                    else
                        tx_cnt_n = tx_cnt - 4'd1;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase

        case (tx_state_n)
            TX_START: tx_n = 1'b0;
            TX_DATA:  tx_n = tx_shift_n[0];
            default:  tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fwrisc_uart_wrapper.sv
// Bench for fwrisc_uart_wrapper with a fast baud setup (2 clocks per tick16,
// 32 clocks per bit) and a 16-byte RAM so a full image load stays short.
module tb_fwrisc_uart_wrapper;

    localparam int CLK_FREQ = 32;
    localparam int BAUD     = 1;
    localparam int DEPTH    = 16;
    localparam int AW       = 4;
    localparam int BIT      = 16 * (CLK_FREQ / (BAUD * 16));

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rx    = 1'b1;
    logic          tx;
    logic          program_receiving;
    logic          program_done;
    logic          program_ov;
    logic [AW-1:0] mem_raddr = '0;
    logic [7:0]    mem_rdata;

    int tests = 0;
    int fails = 0;

    // Model: bytes the host expects the loader to take, in order.
    logic [7:0] exp_bytes [DEPTH];
    int         exp_n = 0;
    int         seen_n = 0;
    logic [7:0] model_mem [DEPTH];
    logic       model_done = 1'b0;
    logic       model_ov = 1'b0;
    logic [8:0] echo_q [$];
    logic [7:0] echo_exp [$];
    logic [7:0] img [DEPTH];

    always #5 clock = ~clock;

    fwrisc_uart_wrapper #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .MEM_DEPTH(DEPTH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .rx               (rx),
        .tx               (tx),
        .program_receiving(program_receiving),
        .program_done     (program_done),
        .program_ov       (program_ov),
        .mem_raddr        (mem_raddr),
        .mem_rdata        (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every cycle: account for loader strobes and track the done flag.
    task automatic compare_loop();
        forever begin
            @(negedge clock);
            if (reset) begin
                seen_n     = 0;
                model_done = 1'b0;
            end else begin
                if (program_receiving === 1'b1) begin
                    tests++;
                    if (seen_n >= exp_n) begin
                        fails++;
                        $display("FAIL unexpected_pulse: strobe seen, accepted %0d expected %0d", seen_n + 1, exp_n);
                    end else begin
                        model_mem[seen_n] = exp_bytes[seen_n];
                        seen_n++;
                        if (seen_n == DEPTH)
                            model_done = 1'b1;
                    end
                end
                check("done_track", {31'd0, program_done}, {31'd0, model_done});
            end
        end
    endtask

    // Decodes echo frames on tx; frames interrupted by reset are dropped.
    task automatic tx_monitor();
        logic [7:0] d;
        logic       sb;
        logic       ab;
        forever begin
            @(negedge clock);
            if (!reset && tx === 1'b0) begin
                ab = 1'b0;
                d  = '0;
                repeat (BIT / 2) begin
                    @(negedge clock);
                    if (reset) ab = 1'b1;
                end
                if (tx !== 1'b0) ab = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) begin
                        @(negedge clock);
                        if (reset) ab = 1'b1;
                    end
                    d[i] = tx;
                end
                repeat (BIT) begin
                    @(negedge clock);
                    if (reset) ab = 1'b1;
                end
                sb = tx;
                if (!ab) echo_q.push_back({sb, d});
            end
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (exp_n < DEPTH) begin
            exp_bytes[exp_n] = b;
            exp_n++;
            echo_exp.push_back(b);
        end else begin
            model_ov = 1'b1;
        end
        send_frame(b, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset    = 1'b1;
        rx       = 1'b1;
        exp_n    = 0;
        model_ov = 1'b0;
        echo_q.delete();
        echo_exp.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_receiving", {31'd0, program_receiving}, 32'd0);
        check("rst_done", {31'd0, program_done}, 32'd0);
        check("rst_ov", {31'd0, program_ov}, 32'd0);
    endtask

    task automatic check_mem(input int a, input logic [7:0] exp, input string name);
        mem_raddr = AW'(a);
        @(posedge clock);
        #1;
        check(name, {24'd0, mem_rdata}, {24'd0, exp});
    endtask

    task automatic wait_tx();
        repeat (700) @(posedge clock);
        #1;
    endtask

    task automatic check_echoes();
        int n;
        check("echo_count", echo_q.size(), echo_exp.size());
        n = (echo_q.size() < echo_exp.size()) ? echo_q.size() : echo_exp.size();
        for (int i = 0; i < n; i++)
            check("echo_byte", {23'd0, echo_q[i]}, {23'd0, 1'b1, echo_exp[i]});
        echo_q.delete();
        echo_exp.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) img[k] = 8'(k * 29) ^ 8'hC3;
        fork
            compare_loop();
            tx_monitor();
        join_none
        repeat (3) @(posedge clock);
        #1;
        do_reset();

        // Single byte, RAM readback and echo bit pattern.
        send_byte(8'hA5);
        check("t1_pulses", seen_n, 1);
        check_mem(0, 8'hA5, "t1_ram0");
        wait_tx();
        check("t1_echo_frame", (echo_q.size() > 0) ? {23'd0, echo_q[0]} : 32'hDEAD, 32'h1A5);
        check_echoes();

        // Framing error is dropped; next byte lands at the next address.
        send_frame(8'h55, 1'b0);
        check("t4_no_pulse", seen_n, 1);
        repeat (20) @(posedge clock);
        #1;
        send_byte(8'h12);
        check("t4_pulses", seen_n, 2);
        check_mem(1, 8'h12, "t4_ram1");
        check_mem(0, 8'hA5, "t4_ram0");
        wait_tx();
        check_echoes();

        // Short low glitch on rx is ignored.
        rx = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        rx = 1'b1;
        repeat (BIT) @(posedge clock);
        #1;
        check("t5_no_pulse", seen_n, 2);
        send_byte(8'h7E);
        check("t5_pulses", seen_n, 3);
        check_mem(2, 8'h7E, "t5_ram2");
        wait_tx();
        check_echoes();

        // Full image load, back to back.
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            send_byte(img[k]);
            if (k == DEPTH - 2)
                check("t2_done_before_last", {31'd0, program_done}, 32'd0);
        end
        check("t2_pulses", seen_n, DEPTH);
        check("t2_done", {31'd0, program_done}, 32'd1);
        check("t2_ov", {31'd0, program_ov}, 32'd0);
        for (int k = 0; k < DEPTH; k++) check_mem(k, model_mem[k], "t2_ram");
        check_mem(0, 8'hC3, "t2_ram_first");
        check_mem(DEPTH - 1, 8'h70, "t2_ram_last");
        wait_tx();
        check_echoes();

        // Byte after completion flags overrun and changes nothing.
        send_byte(8'h3C);
        check("t3_ov", {31'd0, program_ov}, {31'd0, model_ov});
        check("t3_pulses", seen_n, DEPTH);
        check("t3_done", {31'd0, program_done}, 32'd1);
        check_mem(0, 8'hC3, "t3_ram_first");
        check_mem(DEPTH - 1, 8'h70, "t3_ram_last");
        wait_tx();
        check("t3_no_echo", echo_q.size(), 0);

        // Reset in the middle of an RX frame with sticky flags set.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        do_reset();

        // Reset during an echo and a following partial RX frame.
        send_byte(8'h81);
        check("t6_pulse_81", seen_n, 1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        do_reset();
        repeat (400) @(posedge clock);
        #1;
        check("t6_aborted_echo", echo_q.size(), 0);
        send_byte(8'h6B);
        check("t6_pulses", seen_n, 1);
        check_mem(0, 8'h6B, "t6_ram0");
        wait_tx();
        check_echoes();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
